// File: rtl/axis_rx_checker_pkg.sv
// Shared definitions for the rx pattern checker and its transmit-side generator:
// pattern field widths, error codes and checker states.
package axis_rx_checker_pkg;

    localparam int SEQ_W  = 16;
    localparam int WORD_W = 16;

    localparam logic [2:0] ERR_NONE         = 3'd0;
    localparam logic [2:0] ERR_DATA         = 3'd1;
    localparam logic [2:0] ERR_EARLY_LAST   = 3'd2;
    localparam logic [2:0] ERR_MISSING_LAST = 3'd3;
    localparam logic [2:0] ERR_KEEP         = 3'd4;
    localparam logic [2:0] ERR_SEQ          = 3'd5;

    typedef enum logic {
        S_SYNC = 1'b0,
        S_RUN  = 1'b1
    } chk_state_t;

    // keep[i] enables data byte [8i+7:8i], so 4'b1000 selects bits [31:24]
    function automatic logic [31:0] keep_to_mask(input logic [3:0] keep);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{keep[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/axis_rx_checker_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping; clear beats increment.
module sat_counter #(
    parameter int P_W = 32
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_clr,
    input  logic           i_inc,
    output logic [P_W-1:0] o_cnt
);

    logic [P_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {P_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/axis_rx_checker.sv
// Checks the PHY receive AXI-Stream against the deterministic {seq, word} frame pattern
// and reports per-frame verdicts, saturating counters, lock and the first error code.
module axis_rx_checker
    import axis_rx_checker_pkg::*;
#(
    parameter int         P_FRAME_LEN = 16,
    parameter logic [3:0] P_LAST_KEEP = 4'b1111,
    parameter int         P_CNT_W     = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic [31:0]        i_axis_data,
    input  logic [3:0]         i_axis_keep,
    input  logic               i_axis_valid,
    input  logic               i_axis_last,
    output logic               o_axis_ready,
    output logic               o_locked,
    output logic               o_frame_ok,
    output logic               o_frame_err,
    output logic [P_CNT_W-1:0] o_good_cnt,
    output logic [P_CNT_W-1:0] o_err_cnt,
    output logic               o_err_sticky,
    output logic [2:0]         o_err_code
);

    localparam logic [WORD_W-1:0] LP_LAST_WORD = WORD_W'(P_FRAME_LEN - 1);

    chk_state_t        r_state;
    logic              r_ready;
    logic [WORD_W-1:0] r_word;
    logic [SEQ_W-1:0]  r_seq;
    logic              r_seq_known;
    logic              r_acc_err;
    logic [2:0]        r_acc_code;
    logic              r_locked;
    logic              r_frame_ok;
    logic              r_frame_err;
    logic              r_err_sticky;
    logic [2:0]        r_err_code;

    logic              w_beat;
    logic              w_last_word;
    logic              w_adopt;
    logic [3:0]        w_exp_keep;
    logic [31:0]       w_mask;
    logic              w_data_bad;
    logic              w_seq_bad;
    logic [2:0]        w_beat_code;
    logic              w_frame_bad;
    logic [2:0]        w_first_code;
    logic              w_frame_end;
    logic              w_good_inc;
    logic              w_bad_inc;
    logic [SEQ_W-1:0]  w_seq_base;

    assign w_beat      = i_axis_valid & r_ready;
    assign w_last_word = (r_word == LP_LAST_WORD);
    assign w_adopt     = (r_word == '0) && !r_seq_known;
    assign w_exp_keep  = w_last_word ? P_LAST_KEEP : 4'hF;
    // While the sequence is still unknown only the word field of word 0 can be checked
    assign w_mask      = keep_to_mask(w_exp_keep) & (w_adopt ? 32'h0000_FFFF : 32'hFFFF_FFFF);
    assign w_data_bad  = |((i_axis_data ^ {r_seq, r_word}) & w_mask);
    assign w_seq_bad   = (r_word == '0) && r_seq_known && (i_axis_data[31:16] != r_seq);
    assign w_seq_base  = w_adopt ? i_axis_data[31:16] : r_seq;

    always_comb begin
        w_beat_code = ERR_NONE;
        if (w_last_word && !i_axis_last) begin
            w_beat_code = ERR_MISSING_LAST;
        end else if (!w_last_word && i_axis_last) begin
            w_beat_code = ERR_EARLY_LAST;
        end else if (i_axis_keep != w_exp_keep) begin
            w_beat_code = ERR_KEEP;
        end else if (w_seq_bad) begin
            w_beat_code = ERR_SEQ;
        end else if (w_data_bad) begin
            w_beat_code = ERR_DATA;
        end
    end

    assign w_frame_bad  = r_acc_err | (w_beat_code != ERR_NONE);
    assign w_first_code = r_acc_err ? r_acc_code : w_beat_code;
    assign w_frame_end  = w_beat && (r_state == S_RUN) && (i_axis_last || w_last_word);
    assign w_good_inc   = w_frame_end & ~w_frame_bad;
    assign w_bad_inc    = w_frame_end & w_frame_bad;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_SYNC;
            r_ready      <= 1'b0;
            r_word       <= '0;
            r_seq        <= '0;
            r_seq_known  <= 1'b0;
            r_acc_err    <= 1'b0;
            r_acc_code   <= ERR_NONE;
            r_locked     <= 1'b0;
            r_frame_ok   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_code   <= ERR_NONE;
        end else begin
            r_ready     <= 1'b1;
            r_frame_ok  <= w_good_inc;
            r_frame_err <= w_bad_inc;
            if (i_clear) begin
                r_state      <= S_SYNC;
                r_word       <= '0;
                r_seq_known  <= 1'b0;
                r_acc_err    <= 1'b0;
                r_acc_code   <= ERR_NONE;
                r_locked     <= 1'b0;
                r_err_sticky <= 1'b0;
                r_err_code   <= ERR_NONE;
            end else begin
                if (w_bad_inc) begin
                    r_err_sticky <= 1'b1;
                    if (r_err_code == ERR_NONE) begin
                        r_err_code <= w_first_code;
                    end
                end
                case (r_state)
                    S_SYNC: begin
                        if (w_beat && i_axis_last) begin
                            r_state     <= S_RUN;
                            r_word      <= '0;
                            r_seq_known <= 1'b0;
                            r_acc_err   <= 1'b0;
                            r_acc_code  <= ERR_NONE;
                        end
                    end
                    S_RUN: begin
                        if (w_frame_end) begin
                            r_word     <= '0;
                            r_acc_err  <= 1'b0;
                            r_acc_code <= ERR_NONE;
                            r_locked   <= ~w_frame_bad;
                            // A missing last leaves the boundary unknown, so resync
                            if (!i_axis_last) begin
                                r_state     <= S_SYNC;
                                r_seq_known <= 1'b0;
                            end else begin
                                r_seq       <= w_seq_base + 1'b1;
                                r_seq_known <= 1'b1;
                            end
                        end else if (w_beat) begin
                            r_word     <= r_word + 1'b1;
                            r_acc_err  <= w_frame_bad;
                            r_acc_code <= w_first_code;
                            if (w_adopt) begin
                                r_seq       <= i_axis_data[31:16];
                                r_seq_known <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_SYNC;
                endcase
            end
        end
    end

    sat_counter #(.P_W(P_CNT_W)) u_good_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_clear),
        .i_inc (w_good_inc),
        .o_cnt (o_good_cnt)
    );

    sat_counter #(.P_W(P_CNT_W)) u_err_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_clear),
        .i_inc (w_bad_inc),
        .o_cnt (o_err_cnt)
    );

    assign o_axis_ready = r_ready;
    assign o_locked     = r_locked;
    assign o_frame_ok   = r_frame_ok;
    assign o_frame_err  = r_frame_err;
    assign o_err_sticky = r_err_sticky;
    assign o_err_code   = r_err_code;

endmodule

// File: tb/tb_axis_rx_checker.sv
// Directed bench for axis_rx_checker: a default instance (keep 1111, 32-bit counters) and a
// second instance (last keep 1000, 4-bit counters) share one stimulus stream.
module tb_axis_rx_checker;

    localparam int LEN = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        valid;
    logic        last;

    logic        ready, locked, fok, ferr, sticky;
    logic [31:0] good, errc;
    logic [2:0]  code;

    logic        d2_ready, d2_locked, d2_fok, d2_ferr, d2_sticky;
    logic [3:0]  d2_good, d2_errc;
    logic [2:0]  d2_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axis_rx_checker dut (
        .i_clk(clk), .i_rst(rst), .i_clear(clear),
        .i_axis_data(data), .i_axis_keep(keep), .i_axis_valid(valid), .i_axis_last(last),
        .o_axis_ready(ready), .o_locked(locked), .o_frame_ok(fok), .o_frame_err(ferr),
        .o_good_cnt(good), .o_err_cnt(errc), .o_err_sticky(sticky), .o_err_code(code)
    );

    axis_rx_checker #(.P_FRAME_LEN(16), .P_LAST_KEEP(4'b1000), .P_CNT_W(4)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_clear(clear),
        .i_axis_data(data), .i_axis_keep(keep), .i_axis_valid(valid), .i_axis_last(last),
        .o_axis_ready(d2_ready), .o_locked(d2_locked), .o_frame_ok(d2_fok), .o_frame_err(d2_ferr),
        .o_good_cnt(d2_good), .o_err_cnt(d2_errc), .o_err_sticky(d2_sticky), .o_err_code(d2_code)
    );

    task automatic idle();
        @(negedge clk);
        valid = 1'b0;
        last  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        @(negedge clk);
        data  = d;
        keep  = k;
        last  = l;
        valid = 1'b1;
        clear = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        valid = 1'b0;
        last  = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Pattern frame; the caller's following idle() lands on the verdict cycle
    task automatic send_frame(input logic [15:0] seq, input int nwords, input logic with_last,
                              input int flip_word, input logic [3:0] lkeep, input logic garbage,
                              input logic clr_last, input int gap_at);
        for (int w = 0; w < nwords; w++) begin
            logic [31:0] d;
            logic [3:0]  k;
            logic        l;
            d = {seq, 16'(w)};
            if (w == flip_word) d[0] = ~d[0];
            k = (w == LEN - 1) ? lkeep : 4'hF;
            if (w == LEN - 1 && garbage) d[23:0] = 24'h5A3C96;
            l = with_last && (w == nwords - 1);
            send_beat(d, k, l);
            if (l && clr_last) clear = 1'b1;
            if (w == gap_at) idle();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; valid = 1'b0; last = 1'b0; data = '0; keep = '0;
        #3;
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %0b want 0", ready); end
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked: got %0b want 0", locked); end
        checks++; if (fok !== 1'b0 || ferr !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses: got ok=%0b err=%0b want 0 0", fok, ferr); end
        checks++; if (good !== 32'd0 || errc !== 32'd0) begin errors++; $display("[TB] FAIL reset_cnt: got good=%0d err=%0d want 0 0", good, errc); end
        checks++; if (sticky !== 1'b0 || code !== 3'd0) begin errors++; $display("[TB] FAIL reset_err: got sticky=%0b code=%0d want 0 0", sticky, code); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_reset: got %0b want 1", ready); end
    endtask

    task automatic test_clean_frames();
        send_beat(32'hDEAD_BEEF, 4'hF, 1'b1);
        idle();
        checks++; if (locked !== 1'b0 || fok !== 1'b0) begin errors++; $display("[TB] FAIL tail_no_verdict: got locked=%0b ok=%0b want 0 0", locked, fok); end
        for (int i = 0; i < 3; i++) begin
            send_frame(16'(5 + i), LEN, 1'b1, -1, 4'b1111, 1'b0, 1'b0, (i == 0) ? 6 : -1);
            idle();
            checks++; if (fok !== 1'b1 || ferr !== 1'b0) begin errors++; $display("[TB] FAIL clean_verdict%0d: got ok=%0b err=%0b want 1 0", i, fok, ferr); end
            checks++; if (good !== 32'(i + 1) || errc !== 32'd0) begin errors++; $display("[TB] FAIL clean_cnt%0d: got good=%0d err=%0d want %0d 0", i, good, errc, i + 1); end
            checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL clean_locked%0d: got %0b want 1", i, locked); end
        end
        idle();
        checks++; if (fok !== 1'b0) begin errors++; $display("[TB] FAIL ok_one_cycle: got %0b want 0", fok); end
    endtask

    task automatic test_data_err();
        send_frame(16'd8, LEN, 1'b1, 3, 4'b1111, 1'b0, 1'b0, -1);
        idle();
        checks++; if (ferr !== 1'b1 || fok !== 1'b0) begin errors++; $display("[TB] FAIL data_verdict: got ok=%0b err=%0b want 0 1", fok, ferr); end
        checks++; if (errc !== 32'd1 || good !== 32'd3) begin errors++; $display("[TB] FAIL data_cnt: got good=%0d err=%0d want 3 1", good, errc); end
        checks++; if (code !== 3'd1 || sticky !== 1'b1) begin errors++; $display("[TB] FAIL data_code: got code=%0d sticky=%0b want 1 1", code, sticky); end
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL data_unlock: got %0b want 0", locked); end
        send_frame(16'd9, LEN, 1'b1, -1, 4'b1111, 1'b0, 1'b0, -1);
        idle();
        checks++; if (fok !== 1'b1 || good !== 32'd4 || locked !== 1'b1) begin errors++; $display("[TB] FAIL data_recover: got ok=%0b good=%0d locked=%0b want 1 4 1", fok, good, locked); end
        checks++; if (code !== 3'd1) begin errors++; $display("[TB] FAIL data_code_held: got %0d want 1", code); end
    endtask

    task automatic test_early_last();
        do_clear();
        checks++; if (good !== 32'd0 || errc !== 32'd0 || sticky !== 1'b0 || code !== 3'd0 || locked !== 1'b0) begin
            errors++; $display("[TB] FAIL clear: got good=%0d err=%0d sticky=%0b code=%0d locked=%0b want all 0", good, errc, sticky, code, locked); end
        send_beat(32'h0, 4'hF, 1'b1);
        send_frame(16'd20, LEN, 1'b1, -1, 4'b1111, 1'b0, 1'b0, -1);
        idle();
        checks++; if (fok !== 1'b1 || good !== 32'd1) begin errors++; $display("[TB] FAIL early_pre: got ok=%0b good=%0d want 1 1", fok, good); end
        send_frame(16'd21, 10, 1'b1, -1, 4'b1111, 1'b0, 1'b0, -1);
        idle();
        checks++; if (ferr !== 1'b1 || errc !== 32'd1 || code !== 3'd2) begin errors++; $display("[TB] FAIL early_last: got err=%0b cnt=%0d code=%0d want 1 1 2", ferr, errc, code); end
        send_frame(16'd22, LEN, 1'b1, -1, 4'b1111, 1'b0, 1'b0, -1);
        idle();
        checks++; if (fok !== 1'b1 || good !== 32'd2) begin errors++; $display("[TB] FAIL early_recover: got ok=%0b good=%0d want 1 2", fok, good); end
    endtask

    task automatic test_missing_last();
        do_clear();
        send_beat(32'h0, 4'hF, 1'b1);
        send_frame(16'd30, LEN, 1'b1, -1, 4'b1111, 1'b0, 1'b0, -1);
        idle();
        checks++; if (fok !== 1'b1 || locked !== 1'b1) begin errors++; $display("[TB] FAIL miss_pre: got ok=%0b locked=%0b want 1 1", fok, locked); end
        send_frame(16'd31, LEN, 1'b0, -1, 4'b1111, 1'b0, 1'b0, -1);
        idle();
        checks++; if (ferr !== 1'b1 || errc !== 32'd1 || code !== 3'd3 || locked !== 1'b0) begin
            errors++; $display("[TB] FAIL missing_last: got err=%0b cnt=%0d code=%0d locked=%0b want 1 1 3 0", ferr, errc, code, locked); end
        send_frame(16'd32, LEN, 1'b1, -1, 4'b1111, 1'b0, 1'b0, -1);
        idle();
        checks++; if (fok !== 1'b0 || ferr !== 1'b0 || good !== 32'd1 || errc !== 32'd1) begin
            errors++; $display("[TB] FAIL resync_discard: got ok=%0b err=%0b good=%0d errc=%0d want 0 0 1 1", fok, ferr, good, errc); end
        send_frame(16'd40, LEN, 1'b1, -1, 4'b1111, 1'b0, 1'b0, -1);
        idle();
        checks++; if (fok !== 1'b1 || good !== 32'd2 || locked !== 1'b1) begin errors++; $display("[TB] FAIL resync_recover: got ok=%0b good=%0d locked=%0b want 1 2 1", fok, good, locked); end
    endtask

    task automatic test_seq_and_clear();
        do_clear();
        send_beat(32'h0, 4'hF, 1'b1);
        send_frame(16'd50, LEN, 1'b1, -1, 4'b1111, 1'b0, 1'b0, -1);
        idle();
        send_frame(16'd52, LEN, 1'b1, -1, 4'b1111, 1'b0, 1'b0, -1);
        idle();
        checks++; if (ferr !== 1'b1 || code !== 3'd5 || errc !== 32'd1) begin errors++; $display("[TB] FAIL seq_jump: got err=%0b code=%0d cnt=%0d want 1 5 1", ferr, code, errc); end
        send_frame(16'd52, LEN, 1'b1, -1, 4'b1111, 1'b0, 1'b0, -1);
        idle();
        checks++; if (fok !== 1'b1 || good !== 32'd2) begin errors++; $display("[TB] FAIL seq_expected_next: got ok=%0b good=%0d want 1 2", fok, good); end
        send_frame(16'd53, LEN, 1'b1, -1, 4'b1111, 1'b0, 1'b1, -1);
        idle();
        checks++; if (fok !== 1'b1) begin errors++; $display("[TB] FAIL clear_pulse: got %0b want 1", fok); end
        checks++; if (good !== 32'd0 || errc !== 32'd0 || sticky !== 1'b0 || code !== 3'd0 || locked !== 1'b0) begin
            errors++; $display("[TB] FAIL clear_wins: got good=%0d err=%0d sticky=%0b code=%0d locked=%0b want all 0", good, errc, sticky, code, locked); end
        send_frame(16'd54, LEN, 1'b1, -1, 4'b1111, 1'b0, 1'b0, -1);
        idle();
        checks++; if (fok !== 1'b0 || good !== 32'd0) begin errors++; $display("[TB] FAIL clear_to_sync: got ok=%0b good=%0d want 0 0", fok, good); end
    endtask

    task automatic test_keep();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_beat(32'h0, 4'hF, 1'b1);
        send_frame(16'd60, LEN, 1'b1, -1, 4'b1000, 1'b0, 1'b0, -1);
        idle();
        checks++; if (d2_fok !== 1'b1 || d2_good !== 4'd1) begin errors++; $display("[TB] FAIL keep_pre: got ok=%0b good=%0d want 1 1", d2_fok, d2_good); end
        send_frame(16'd61, LEN, 1'b1, -1, 4'b1100, 1'b0, 1'b0, -1);
        idle();
        checks++; if (d2_ferr !== 1'b1 || d2_code !== 3'd4 || d2_errc !== 4'd1) begin errors++; $display("[TB] FAIL keep_err: got err=%0b code=%0d cnt=%0d want 1 4 1", d2_ferr, d2_code, d2_errc); end
        send_frame(16'd62, LEN, 1'b1, -1, 4'b1000, 1'b1, 1'b0, -1);
        idle();
        checks++; if (d2_fok !== 1'b1 || d2_good !== 4'd2) begin errors++; $display("[TB] FAIL keep_masked: got ok=%0b good=%0d want 1 2", d2_fok, d2_good); end
    endtask

    task automatic test_saturate();
        do_clear();
        send_beat(32'h0, 4'hF, 1'b1);
        for (int i = 0; i < 20; i++) begin
            int e;
            send_frame(16'(100 + i), LEN, 1'b1, -1, 4'b1000, 1'b0, 1'b0, -1);
            idle();
            e = (i + 1 > 15) ? 15 : i + 1;
            checks++; if (d2_good !== 4'(e)) begin errors++; $display("[TB] FAIL sat_cnt%0d: got %0d want %0d", i, d2_good, e); end
        end
    endtask

    task automatic test_async_reset();
        send_beat({16'd120, 16'd0}, 4'hF, 1'b0);
        send_beat({16'd120, 16'd1}, 4'hF, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (d2_good !== 4'd0 || d2_locked !== 1'b0 || d2_ready !== 1'b0 || d2_sticky !== 1'b0 || d2_code !== 3'd0) begin
            errors++; $display("[TB] FAIL async_reset_d2: got good=%0d locked=%0b ready=%0b sticky=%0b code=%0d want all 0", d2_good, d2_locked, d2_ready, d2_sticky, d2_code); end
        checks++; if (errc !== 32'd0 || good !== 32'd0 || sticky !== 1'b0 || code !== 3'd0 || ready !== 1'b0) begin
            errors++; $display("[TB] FAIL async_reset: got good=%0d err=%0d sticky=%0b code=%0d ready=%0b want all 0", good, errc, sticky, code, ready); end
        valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL timeout: got no finish want finish before 500000");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_clean_frames();
        test_data_err();
        test_early_last();
        test_missing_last();
        test_seq_and_clear();
        test_keep();
        test_saturate();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
